hash_job_responder: RTL
=======================

HASH_JOB_RESPONDER -- requirements
Module: hash_job_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256: word depth of the shared memory (power of two).
REQ-002 SHALL have parameter NUM_NONCES, default 16: number of result words scanned per job.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096: watchdog limit (used only under HASH_JOB_TIMEOUT_EN).
REQ-004 SHALL have port clk  input  1  sole clock.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port job_go  input  1  one-cycle job request.
REQ-007 SHALL have port job_header_addr  input  16  header base address.
REQ-008 SHALL have port job_out_addr  input  16  result base address.
REQ-009 SHALL have port job_done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port job_err  output  1  one-cycle abort pulse.
REQ-011 SHALL have port best_idx  output  $clog2(NUM_NONCES)  index of minimum result word.
REQ-012 SHALL have port best_hash  output  32  minimum result word.
REQ-013 SHALL have port start  output  1  start pulse to hasher.
REQ-014 SHALL have ports header_addr, hash_out_addr  output  16 each  addresses to hasher.
REQ-015 SHALL have port done  input  1  hasher idle level.
REQ-016 SHALL have ports mem_we (1), memory_addr (16), memory_write_data (32)  input  hasher memory request.
REQ-017 SHALL have port memory_read_data  output  32  registered read data to hasher.
REQ-018 SHALL have ports host_req, host_we (1), host_addr (16), host_wdata (32)  input  host access.
REQ-019 SHALL have ports host_gnt, host_rvalid (1), host_rdata (32)  output  host grant/read return.

Function
REQ-020 SHALL index memory with addr[log2(DEPTH)-1:0]; higher address bits ignored (wrap).
REQ-021 SHALL return memory_read_data = mem[memory_addr] one clk after the address, every cycle regardless of owner.
REQ-022 SHALL give memory ownership to the host in IDLE/REPORT, to the hasher in START/WAIT_BUSY/WAIT_DONE, internal in SCAN.
REQ-023 host_gnt SHALL equal host_req while host owns, else 0; host reads SHALL return host_rdata with host_rvalid one cycle after grant.
REQ-024 mem_we SHALL write only while the hasher owns memory; otherwise it is ignored.
REQ-025 FSM SHALL be IDLE -> START on job_go (ignored outside IDLE), latching both addresses onto header_addr/hash_out_addr.
REQ-026 START SHALL assert start for exactly one cycle, then go to WAIT_BUSY.
REQ-027 WAIT_BUSY SHALL wait for done=0, then go to WAIT_DONE; WAIT_DONE SHALL wait for done=1, then go to SCAN.
REQ-028 SCAN SHALL read out_addr+0..NUM_NONCES-1 (1-cycle latency, pipelined, NUM_NONCES+1 cycles), tracking the unsigned minimum; ties keep the lowest index.
REQ-029 REPORT SHALL update best_idx/best_hash, pulse job_done one cycle, and return to IDLE.
REQ-030 A host_req arriving the same cycle as job_go SHALL be granted; the FSM still enters START next cycle.

Reset
REQ-031 On reset SHALL force IDLE; start, job_done, job_err, host_gnt, host_rvalid = 0; best_idx, best_hash, header_addr, hash_out_addr, memory_read_data, host_rdata = 0.
REQ-032 Memory contents SHALL NOT be reset; reset mid-job SHALL abort with no job_done or job_err pulse.

Configuration
REQ-033 With HASH_JOB_TIMEOUT_EN defined, a counter SHALL run in WAIT_BUSY/WAIT_DONE; on reaching TIMEOUT_CYCLES it SHALL pulse job_err, leave best_* unchanged, and return to IDLE.
REQ-034 Without HASH_JOB_TIMEOUT_EN, there SHALL be no counter, no abort path, and job_err SHALL be tied 0.

Structure
REQ-035 A shared package hash_job_pkg SHALL hold the FSM state enum (IDLE, START, WAIT_BUSY, WAIT_DONE, SCAN, REPORT) and default DEPTH/NUM_NONCES constants.
REQ-036 The memory array with its two registered ports SHALL be a sub-module hash_job_ram; the min-scan SHALL remain in the top.

Verification
REQ-037 Host writes 0xDEADBEEF to 0x0005, then reads 0x0005 -> host_rdata=0xDEADBEEF with host_rvalid one cycle after grant.
REQ-038 Host write to 0x0105 (DEPTH=256) -> a read of 0x0005 returns the written word.
REQ-039 job_go with header_addr=0x0000, out_addr=0x0010; stub hasher writes results {9,7,3,3,…,8} -> job_done pulse, best_idx=2, best_hash=3.
REQ-040 host_req asserted during WAIT_DONE -> host_gnt=0 until REPORT; the stub hasher write to the same address wins.
REQ-041 With HASH_JOB_TIMEOUT_EN and TIMEOUT_CYCLES=64, stub holds done=0 -> job_err pulse after 64 cycles, FSM IDLE, best_* unchanged.
REQ-042 reset asserted in SCAN -> all outputs 0 and state IDLE, with no job_done pulse.

Source files
------------

// File: rtl/hash_job_pkg.sv
// hash_job_pkg: FSM states and default sizing shared by the hash job responder.
package hash_job_pkg;
  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, SCAN, REPORT} state_t;
  localparam int DEFAULT_DEPTH = 256;
  localparam int DEFAULT_NUM_NONCES = 16;
endpackage

// File: rtl/hash_job_ram.sv
// hash_job_ram: single write port, two registered read ports; contents are never reset.
module hash_job_ram
  import hash_job_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr_a,
  output logic [31:0]              rdata_a,
  input  logic [$clog2(DEPTH)-1:0] raddr_b,
  output logic [31:0]              rdata_b
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      rdata_a <= mem[raddr_a];
      rdata_b <= mem[raddr_b];
    end
endmodule

// File: rtl/hash_job_responder.sv
// hash_job_responder: arbitrates a shared RAM between host and hasher, runs one job, reports the minimum result.
// Define HASH_JOB_TIMEOUT_EN to add a watchdog that aborts a stalled hasher with a job_err pulse.
module hash_job_responder
  import hash_job_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int NUM_NONCES = DEFAULT_NUM_NONCES,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          job_go,
  input  logic [15:0]                   job_header_addr,
  input  logic [15:0]                   job_out_addr,
  output logic                          job_done,
  output logic                          job_err,
  output logic [$clog2(NUM_NONCES)-1:0] best_idx,
  output logic [31:0]                   best_hash,
  output logic                          start,
  output logic [15:0]                   header_addr,
  output logic [15:0]                   hash_out_addr,
  input  logic                          done,
  input  logic                          mem_we,
  input  logic [15:0]                   memory_addr,
  input  logic [31:0]                   memory_write_data,
  output logic [31:0]                   memory_read_data,
  input  logic                          host_req,
  input  logic                          host_we,
  input  logic [15:0]                   host_addr,
  input  logic [31:0]                   host_wdata,
  output logic                          host_gnt,
  output logic                          host_rvalid,
  output logic [31:0]                   host_rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(NUM_NONCES);
  localparam int CW = $clog2(NUM_NONCES + 1);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [IW-1:0] min_idx, nxt_idx;
  logic [31:0] min_hash, nxt_hash, scan_data, wdata;
  logic [15:0] scan_addr;
  logic [AW-1:0] waddr, addr_b;
  logic host_owns, hasher_owns, scan_last, take, abort, we;
  logic unused_bits;
  assign unused_bits = ^{memory_addr[15:AW], host_addr[15:AW], scan_addr[15:AW]};
  assign host_owns = state == IDLE || state == REPORT;
  assign hasher_owns = state == START || state == WAIT_BUSY || state == WAIT_DONE;
  assign host_gnt = host_owns & host_req;
  assign start = state == START;
  assign job_done = state == REPORT;
  assign we = hasher_owns ? mem_we : host_gnt & host_we;
  assign waddr = hasher_owns ? memory_addr[AW-1:0] : host_addr[AW-1:0];
  assign wdata = hasher_owns ? memory_write_data : host_wdata;
  assign scan_addr = hash_out_addr + 16'(cnt);
  assign addr_b = state == SCAN ? scan_addr[AW-1:0] : host_addr[AW-1:0];
  assign host_rdata = scan_data;
  // scan_data at count k is result word k-1; strict less-than keeps the lowest index on ties
  assign take = cnt == CW'(1) || scan_data < min_hash;
  assign nxt_hash = take ? scan_data : min_hash;
  assign nxt_idx = take ? IW'(cnt - CW'(1)) : min_idx;
  assign scan_last = state == SCAN && cnt == CW'(NUM_NONCES);
  hash_job_ram #(.DEPTH(DEPTH)) u_ram (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(memory_addr[AW-1:0]), .rdata_a(memory_read_data),
    .raddr_b(addr_b), .rdata_b(scan_data)
  );
`ifdef HASH_JOB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tcnt;
  logic waiting;
  assign waiting = state == WAIT_BUSY || state == WAIT_DONE;
  assign abort = waiting && tcnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tcnt <= '0;
      job_err <= 1'b0;
    end else begin
      tcnt <= waiting ? tcnt + TW'(1) : '0;
      job_err <= abort;
    end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign abort = 1'b0;
  assign job_err = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (job_go) nxt = START;
      START:     nxt = WAIT_BUSY;
      WAIT_BUSY: if (!done) nxt = WAIT_DONE;
      WAIT_DONE: if (done) nxt = SCAN;
      SCAN:      if (scan_last) nxt = REPORT;
      REPORT:    nxt = IDLE;
      default:   nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      header_addr <= '0;
      hash_out_addr <= '0;
      best_idx <= '0;
      best_hash <= '0;
      min_idx <= '0;
      min_hash <= '0;
      cnt <= '0;
      host_rvalid <= 1'b0;
    end else begin
      host_rvalid <= host_gnt & ~host_we;
      cnt <= state == SCAN ? cnt + CW'(1) : '0;
      if (state == IDLE && job_go) begin
        header_addr <= job_header_addr;
        hash_out_addr <= job_out_addr;
      end
      if (state == SCAN && cnt != '0) begin
        min_idx <= nxt_idx;
        min_hash <= nxt_hash;
      end
      if (scan_last) begin
        best_idx <= nxt_idx;
        best_hash <= nxt_hash;
      end
    end
endmodule
